// File: rtl/bb_sample_packer.sv
// rtl/bb_sample_packer.sv - packs 8-bit I/Q samples into 32-bit words, buffers them, streams out on AXI4-Stream
//
// Purpose: two consecutive I/Q samples form one word {imag1,real1,imag0,real0}.
// Completed words are pushed into a FIFO whose head is moved into a registered output stage.
// m_tlast marks every FRAME_WORDS-th delivered word. Words that cannot be stored are
// counted as drops.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   enable                capture enable; a rising edge starts a fresh frame
//   stat_clear            one-cycle pulse clearing overflow and drop_count
//   dv_in, real_in,
//   imag_in               input sample stream
//   m_tdata, m_tvalid,
//   m_tready, m_tlast     AXI4-Stream master
//   overflow, drop_count  sticky drop flag and saturating drop counter
//   fifo_level            words held (FIFO storage plus output register)
module bb_sample_packer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WORDS = 1024,
  localparam int AW   = $clog2(FIFO_DEPTH),
  localparam int LW   = AW + 1,
  localparam int FW_W = $clog2(FRAME_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          stat_clear,
  input  logic          dv_in,
  input  logic [7:0]    real_in,
  input  logic [7:0]    imag_in,
  output logic [31:0]   m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          overflow,
  output logic [15:0]   drop_count,
  output logic [LW-1:0] fifo_level
);

  logic            enable_q;
  logic            phase_q, phase_d;
  logic [15:0]     half_q, half_d;
  logic [FW_W-1:0] frame_q, frame_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   mem_cnt_q, mem_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [32:0]     out_data_q, out_data_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic [32:0]     mem [FIFO_DEPTH];

  logic            rise, phase_eff, capture, word_done, pop, push_ok, drop, load, frame_last;
  logic [FW_W-1:0] frame_eff;
  logic [LW-1:0]   level;
  logic [32:0]     push_word;

  always_comb begin
    // An enable rising edge acts as if phase and frame counter were already zero,
    // so a sample arriving on that very edge becomes sample0 of word 0.
    rise       = enable && !enable_q;
    phase_eff  = rise ? 1'b0 : phase_q;
    frame_eff  = rise ? '0 : frame_q;
    capture    = enable && dv_in;
    word_done  = capture && phase_eff;
    pop        = out_valid_q && m_tready;
    level      = mem_cnt_q + {{AW{1'b0}}, out_valid_q};
    push_ok    = word_done && ((level < LW'(FIFO_DEPTH)) || pop);
    drop       = word_done && !push_ok;
    // Refill the output register whenever it is empty or being consumed this edge.
    load       = (mem_cnt_q != '0) && (!out_valid_q || pop);
    frame_last = (frame_eff == FW_W'(FRAME_WORDS - 1));
    push_word  = {frame_last, imag_in, real_in, half_q};

    phase_d = phase_eff;
    if (!enable)      phase_d = 1'b0;
    else if (capture) phase_d = ~phase_eff;

    half_d = half_q;
    if (capture && !phase_eff) half_d = {imag_in, real_in};

    frame_d = frame_eff;
    if (push_ok) frame_d = frame_last ? '0 : frame_eff + FW_W'(1);

    wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q + LW'(push_ok) - LW'(load);

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem[rd_ptr_q];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    // A drop on the same edge as stat_clear leaves exactly that one drop recorded.
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (stat_clear)                 drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (stat_clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q    <= 1'b0;
      phase_q     <= 1'b0;
      half_q      <= '0;
      frame_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      enable_q    <= enable;
      phase_q     <= phase_d;
      half_q      <= half_d;
      frame_q     <= frame_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage array needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_word;
  end

  assign m_tdata    = out_data_q[31:0];
  assign m_tlast    = out_data_q[32];
  assign m_tvalid   = out_valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_bb_sample_packer.sv
// tb/tb_bb_sample_packer.sv - scoreboard bench for bb_sample_packer
module tb_bb_sample_packer;
  localparam int DEPTH = 16;
  localparam int FW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          stat_clear = 1'b0;
  logic          dv_in = 1'b0;
  logic [7:0]    real_in = '0;
  logic [7:0]    imag_in = '0;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [LW-1:0] fifo_level;

  bb_sample_packer #(.FIFO_DEPTH(DEPTH), .FRAME_WORDS(FW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .stat_clear(stat_clear),
    .dv_in(dv_in), .real_in(real_in), .imag_in(imag_in),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .overflow(overflow), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];
  logic        m_phase = 1'b0;
  logic [15:0] m_half  = '0;
  int          m_fcnt  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && m_tvalid) begin
      if (m_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 64'(m_tdata), 64'hDEAD_0000_0000);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("tdata", 64'(m_tdata), 64'(e[31:0]));
          chk("tlast", 64'(m_tlast), 64'(e[32]));
        end
      end else if (exp_q.size() != 0) begin
        chk("hold_tdata", 64'(m_tdata), 64'(exp_q[0][31:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp(input logic [7:0] r, input logic [7:0] im, input bit drop);
    real_in = r; imag_in = im; dv_in = 1'b1;
    if (!m_phase) begin
      m_half  = {im, r};
      m_phase = 1'b1;
    end else begin
      m_phase = 1'b0;
      if (!drop) begin
        exp_q.push_back({(m_fcnt == FW - 1), im, r, m_half});
        m_fcnt = (m_fcnt == FW - 1) ? 0 : m_fcnt + 1;
      end
    end
    tick();
    dv_in = 1'b0;
  endtask

  task automatic rand_word(input bit drop);
    smp(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    smp(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), drop);
  endtask

  task automatic reenable();
    enable = 1'b0; m_phase = 1'b0;
    tick();
    enable = 1'b1; m_fcnt = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      tick();
      t++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    reset = 1'b0;
    tick();

    // Basic packing and first-word latency.
    enable = 1'b1; m_tready = 1'b1; m_fcnt = 0;
    smp(8'd1, 8'hFF, 1'b0);
    smp(8'd2, 8'hFE, 1'b0);
    chk("lat_tvalid0", 64'(m_tvalid), 64'd0);
    chk("lat_level1", 64'(fifo_level), 64'd1);
    chk("w0_model", 64'(exp_q[0][31:0]), 64'hFE02FF01);
    smp(8'd3, 8'hFD, 1'b0);
    chk("lat_tvalid1", 64'(m_tvalid), 64'd1);
    smp(8'd4, 8'hFC, 1'b0);
    chk("w1_model", 64'(exp_q[exp_q.size()-1][31:0]), 64'hFC04FD03);
    drain();
    chk("t1_ovf", 64'(overflow), 64'd0);

    // Framing over 16 continuous samples.
    reenable();
    for (int w = 0; w < 8; w++) rand_word(1'b0);
    drain();

    // Overflow: stalled sink, DEPTH+3 words.
    m_tready = 1'b0;
    reenable();
    for (int w = 0; w < DEPTH + 3; w++) rand_word(w >= DEPTH);
    chk("ovf_level", 64'(fifo_level), 64'(DEPTH));
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd3);

    // stat_clear coincident with a drop, then a plain clear.
    smp(8'h11, 8'h22, 1'b0);
    stat_clear = 1'b1;
    smp(8'h33, 8'h44, 1'b1);
    stat_clear = 1'b0;
    chk("clr_drop_ovf", 64'(overflow), 64'd1);
    chk("clr_drop_cnt", 64'(drop_count), 64'd1);
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_cnt", 64'(drop_count), 64'd0);

    // Full FIFO, ready returns on the edge a word completes.
    smp(8'h55, 8'h66, 1'b0);
    m_tready = 1'b1;
    smp(8'h77, 8'h88, 1'b0);
    chk("full_pp_level", 64'(fifo_level), 64'(DEPTH));
    chk("full_pp_drops", 64'(drop_count), 64'd0);
    drain();
    chk("drained_level", 64'(fifo_level), 64'd0);

    // Half word discarded across enable toggle; frame restarts.
    reenable();
    for (int s = 0; s < 3; s++) smp(8'(8'h10 + s), 8'(8'h20 + s), 1'b0);
    reenable();
    smp(8'h40, 8'h50, 1'b0);
    smp(8'h41, 8'h51, 1'b0);
    for (int w = 0; w < 3; w++) rand_word(1'b0);
    drain();

    // Reset mid-frame with buffered data.
    m_tready = 1'b0;
    reenable();
    for (int w = 0; w < 8; w++) rand_word(1'b0);
    chk("pre_rst_level", 64'(fifo_level), 64'd8);
    reset = 1'b1;
    #1;
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_drops", 64'(drop_count), 64'd0);
    exp_q.delete();
    m_phase = 1'b0; m_fcnt = 0;
    tick();
    reset = 1'b0;
    m_tready = 1'b1;
    for (int w = 0; w < 5; w++) rand_word(1'b0);
    drain();
    chk("end_ovf", 64'(overflow), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
